// File: rtl/sin_wave_gen_if.sv
// Handshake/bus bundle between the sine generator and its surroundings.
// Includes the combinational quarter-wave ROM lookup pair (rom_addr out, rom_data back).
interface sin_wave_gen_if #(
  parameter int PHASE_W = 16
);
  logic               load;
  logic [PHASE_W-1:0] freq_word;
  logic               en;
  logic               clear;
  logic [7:0]         rom_addr;
  logic [6:0]         rom_data;
  logic [7:0]         sample;
  logic               sample_valid;
  logic               wrap;

  modport master (
    output load, freq_word, en, clear, rom_data,
    input  rom_addr, sample, sample_valid, wrap
  );

  modport slave (
    input  load, freq_word, en, clear, rom_data,
    output rom_addr, sample, sample_valid, wrap
  );
endinterface

// File: rtl/sin_wave_gen.sv
// Quarter-wave sine DDS: phase accumulator, mirrored ROM lookup, sign from quadrant.
// Sample appears one cycle after an enabled edge; no backpressure, en alone paces output.
module sin_wave_gen #(
  parameter int PHASE_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  sin_wave_gen_if.slave  bus
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] freq_reg;
  logic [PHASE_W:0]   phase_sum;
  logic [1:0]         quad;
  logic [7:0]         idx;
  logic [7:0]         ext;
  logic [7:0]         sample_next;
  logic [7:0]         sample_reg;
  logic               valid_reg;
  logic               wrap_reg;

  assign quad = phase[PHASE_W-1 -: 2];
  assign idx  = phase[PHASE_W-3 -: 8];

  // Quadrants 1 and 3 walk the quarter table backwards.
  assign bus.rom_addr = quad[0] ? ~idx : idx;

  // 7-bit magnitude keeps the negated result inside -127..+127.
  assign ext         = {1'b0, bus.rom_data};
  assign sample_next = quad[1] ? (~ext + 8'd1) : ext;

  assign phase_sum = {1'b0, phase} + {1'b0, freq_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= '0;
      freq_reg   <= '0;
      sample_reg <= 8'h00;
      valid_reg  <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      if (bus.load)
        freq_reg <= bus.freq_word;

      if (bus.clear) begin
        phase     <= '0;
        valid_reg <= 1'b0;
        wrap_reg  <= 1'b0;
      end else if (bus.en) begin
        // Increment uses freq_reg as it stood before any same-edge load.
        phase      <= phase_sum[PHASE_W-1:0];
        sample_reg <= sample_next;
        valid_reg  <= 1'b1;
        wrap_reg   <= phase_sum[PHASE_W];
      end else begin
        valid_reg <= 1'b0;
        wrap_reg  <= 1'b0;
      end
    end
  end

  assign bus.sample       = sample_reg;
  assign bus.sample_valid = valid_reg;
  assign bus.wrap         = wrap_reg;

endmodule
